// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// op encodings, default busy durations and FSM state type.
package muldiv_ctrl_pkg;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width able to hold the larger of the two busy durations.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit: computes at issue, holds busy for a fixed
// number of cycles, then commits the result to the architectural HI/LO.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output state_t      dbg_state
);

    localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          busy_next;
    logic [31:0]   hi_next, lo_next;
    logic [31:0]   hi_tmp, lo_tmp, hi_tmp_next, lo_tmp_next;
    logic          commit, commit_next;

    logic               issue_ok;
    logic        [31:0] div_b;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;

    // Divisor forced to 1 on zero so the datapath never divides by zero;
    // the commit flag then suppresses the HI/LO write.
    assign div_b  = (B == 32'd0) ? 32'd1 : B;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign quot_s = $signed(A) / $signed(div_b);
    assign rem_s  = $signed(A) % $signed(div_b);
    assign quot_u = A / div_b;
    assign rem_u  = A % div_b;

    assign issue_ok  = (state == ST_IDLE) && start && !cancel;
    assign dbg_state = state;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        busy_next   = busy;
        hi_next     = HI;
        lo_next     = LO;
        hi_tmp_next = hi_tmp;
        lo_tmp_next = lo_tmp;
        commit_next = commit;
        case (state)
            ST_IDLE: begin
                if (issue_ok) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            hi_tmp_next = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                            lo_tmp_next = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                            commit_next = 1'b1;
                            cnt_next    = MUL_N;
                            busy_next   = 1'b1;
                            state_next  = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_tmp_next = (op == OP_DIV) ? rem_s  : rem_u;
                            lo_tmp_next = (op == OP_DIV) ? quot_s : quot_u;
                            commit_next = (B != 32'd0);
                            cnt_next    = DIV_N;
                            busy_next   = 1'b1;
                            state_next  = ST_RUN;
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start and cancel are deliberately ignored here: the issuing
                // instruction has already left E.
                if (cnt <= CW'(1)) begin
                    if (commit) begin
                        hi_next = hi_tmp;
                        lo_next = lo_tmp;
                    end
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            commit <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy   <= busy_next;
            HI     <= hi_next;
            LO     <= lo_next;
            hi_tmp <= hi_tmp_next;
            lo_tmp <= lo_tmp_next;
            commit <= commit_next;
        end
    end

endmodule
